// File: rtl/mc_rb_skew_fuse_cap_pkg.sv
// ---------------------------------------------------------------------------
// mc_rb_skew_pkg
// Shared definitions for the eFuse skew-code capture block: default geometry,
// FSM state encoding and the terminal-address helper.
// No ports (package).
// ---------------------------------------------------------------------------
package mc_rb_skew_pkg;

    localparam int DEF_NUM_LANES = 4;
    localparam int DEF_SKEW_W    = 5;
    localparam int DEF_ADDR_W    = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_CAPTURE = 2'd1;
    localparam state_t ST_COMMIT  = 2'd2;

    // One fuse bit per address, addresses start at 1, so the final address
    // equals the total number of code bits.
    function automatic int last_addr(input int num_lanes, input int skew_w);
        return num_lanes * skew_w;
    endfunction

endpackage

// File: rtl/mc_rb_skew_fuse_cap_if.sv
// ---------------------------------------------------------------------------
// mc_rb_skew_fuse_cap_if
// Bundles the address/data stream from the upstream skew address counter and
// the committed-code outputs of the capture block.
//   skew_addr_cntr_i   address step, 0 = idle          (master -> slave)
//   mc_rb_ef1_sdata_i  serial fuse bit for that step    (master -> slave)
//   skew_code_o        committed per-lane codes         (slave -> master)
//   skew_load_o        one-cycle update strobe          (slave -> master)
//   skew_vld_o         sticky: a commit happened        (slave -> master)
//   seq_err_o          sticky: last sequence was bad    (slave -> master)
//   busy_o             capture or commit in progress    (slave -> master)
// ---------------------------------------------------------------------------
interface mc_rb_skew_fuse_cap_if
    import mc_rb_skew_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int SKEW_W    = DEF_SKEW_W,
    parameter int ADDR_W    = DEF_ADDR_W
);

    logic [ADDR_W-1:0]           skew_addr_cntr_i;
    logic                        mc_rb_ef1_sdata_i;
    logic [NUM_LANES*SKEW_W-1:0] skew_code_o;
    logic                        skew_load_o;
    logic                        skew_vld_o;
    logic                        seq_err_o;
    logic                        busy_o;

    modport master (
        output skew_addr_cntr_i,
        output mc_rb_ef1_sdata_i,
        input  skew_code_o,
        input  skew_load_o,
        input  skew_vld_o,
        input  seq_err_o,
        input  busy_o
    );

    modport slave (
        input  skew_addr_cntr_i,
        input  mc_rb_ef1_sdata_i,
        output skew_code_o,
        output skew_load_o,
        output skew_vld_o,
        output seq_err_o,
        output busy_o
    );

endinterface

// File: rtl/mc_rb_skew_fuse_cap_shadow.sv
// ---------------------------------------------------------------------------
// mc_rb_skew_shadow
// Shadow register that collects fuse bits one at a time, plus the lane/bit
// index counters that select where the next bit lands.
//   clk      fuse serial clock
//   rst_n    synchronous active-low reset
//   wr_en    write data into the current lane/bit slot, then advance
//   idx_clr  return the indices to lane 0 / bit 0 (ignored while wr_en)
//   data     serial fuse bit
//   shadow   collected bits, lane n at [n*SKEW_W +: SKEW_W]
// ---------------------------------------------------------------------------
module mc_rb_skew_shadow
    import mc_rb_skew_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int SKEW_W    = DEF_SKEW_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic                        idx_clr,
    input  logic                        data,
    output logic [NUM_LANES*SKEW_W-1:0] shadow
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int BIT_W  = (SKEW_W > 1) ? $clog2(SKEW_W) : 1;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SKEW_W - 1);

    logic [LANE_W-1:0]                  lane_idx;
    logic [BIT_W-1:0]                   bit_idx;
    logic [NUM_LANES-1:0][SKEW_W-1:0]   shadow_q;

    // Index counters replace a divide/modulo of the address: bit_idx walks
    // through a lane and bumps lane_idx on the same edge it wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_idx <= '0;
            bit_idx  <= '0;
        end else if (wr_en) begin
            if (bit_idx == BIT_LAST) begin
                bit_idx  <= '0;
                lane_idx <= (lane_idx == LANE_LAST) ? '0 : lane_idx + 1'b1;
            end else begin
                bit_idx <= bit_idx + 1'b1;
            end
        end else if (idx_clr) begin
            lane_idx <= '0;
            bit_idx  <= '0;
        end
    end

    // Shadow is deliberately not cleared between sequences; a complete
    // sequence overwrites every bit before it can be committed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (wr_en) begin
            shadow_q[lane_idx][bit_idx] <= data;
        end
    end

    assign shadow = shadow_q;

endmodule

// File: rtl/mc_rb_skew_fuse_cap.sv
// ---------------------------------------------------------------------------
// mc_rb_skew_fuse_cap
// Consumes the skew address counter stream, captures one fuse bit per
// address 1..LAST_ADDR, checks strict sequencing and commits the complete
// shadow into the per-lane skew codes with a one-cycle load strobe.
//   mc_rb_ef1_sclk_i    fuse serial clock (only clock)
//   gctl_rclk_orst_n_i  synchronous active-low reset
//   bus                 slave side of mc_rb_skew_fuse_cap_if (address/data in,
//                       code/load/vld/err/busy out)
// Parameters must match those of the connected interface instance.
// ---------------------------------------------------------------------------
module mc_rb_skew_fuse_cap
    import mc_rb_skew_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int SKEW_W    = DEF_SKEW_W,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                  mc_rb_ef1_sclk_i,
    input  logic                  gctl_rclk_orst_n_i,
    mc_rb_skew_fuse_cap_if.slave  bus
);

    localparam int CODE_W    = NUM_LANES * SKEW_W;
    localparam int LAST_ADDR = last_addr(NUM_LANES, SKEW_W);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TWO  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

    // The terminal address has to be representable on the address bus.
    generate
        if (LAST_ADDR > (2 ** ADDR_W) - 1) begin : g_bad_geometry
            $error("mc_rb_skew_fuse_cap: LAST_ADDR does not fit in ADDR_W bits");
        end
    endgenerate

    logic                clk;
    logic                rst_n;
    logic [ADDR_W-1:0]   addr;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   expected_q;
    logic [ADDR_W-1:0]   expected_d;

    logic                addr_is_one;
    logic                addr_is_exp;
    logic                addr_is_last;
    logic                addr_in_seq;

    logic                wr_en;
    logic                idx_clr;
    logic                err_set;
    logic                commit;

    logic [CODE_W-1:0]   shadow;
    logic [CODE_W-1:0]   skew_code_q;
    logic                load_q;
    logic                vld_q;
    logic                err_q;

    assign clk   = mc_rb_ef1_sclk_i;
    assign rst_n = gctl_rclk_orst_n_i;
    assign addr  = bus.skew_addr_cntr_i;

    assign addr_is_one  = (addr == ADDR_ONE);
    assign addr_is_exp  = (addr == expected_q);
    assign addr_is_last = (addr == ADDR_LAST);
    // Addresses that only make sense mid-sequence; seeing one while idle
    // means the start of the sequence was missed.
    assign addr_in_seq  = (addr >= ADDR_TWO) && (addr <= ADDR_LAST);

    mc_rb_skew_shadow #(
        .NUM_LANES (NUM_LANES),
        .SKEW_W    (SKEW_W)
    ) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .idx_clr (idx_clr),
        .data    (bus.mc_rb_ef1_sdata_i),
        .shadow  (shadow)
    );

    // State register plus the expected-address tracker that moves with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            expected_q <= ADDR_ONE;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
        end
    end

    // Next-state logic: any deviation from the expected address drops back
    // to IDLE; COMMIT lasts exactly one cycle and ignores the address bus.
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        case (state_q)
            ST_IDLE: begin
                if (addr_is_one) begin
                    state_d    = ST_CAPTURE;
                    expected_d = ADDR_TWO;
                end
            end
            ST_CAPTURE: begin
                if (addr_is_exp) begin
                    expected_d = expected_q + 1'b1;
                    if (addr_is_last) begin
                        state_d = ST_COMMIT;
                    end
                end else begin
                    state_d    = ST_IDLE;
                    expected_d = ADDR_ONE;
                end
            end
            ST_COMMIT: begin
                state_d    = ST_IDLE;
                expected_d = ADDR_ONE;
            end
            default: begin
                state_d    = ST_IDLE;
                expected_d = ADDR_ONE;
            end
        endcase
    end

    // Per-state control strobes. Indices are held at zero whenever no write
    // happens outside a healthy capture, so each new sequence starts at bit 0.
    always_comb begin
        wr_en   = 1'b0;
        idx_clr = 1'b1;
        err_set = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (addr_is_one) begin
                    wr_en = 1'b1;
                end else if (addr_in_seq) begin
                    err_set = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (addr_is_exp) begin
                    wr_en = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            ST_COMMIT: begin
                commit = 1'b1;
            end
            default: begin
                idx_clr = 1'b1;
            end
        endcase
    end

    // Registered outputs: the load strobe is the registered commit, so it can
    // never be high two cycles running. A commit wins over any stale error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skew_code_q <= '0;
            load_q      <= 1'b0;
            vld_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            load_q <= commit;
            if (commit) begin
                skew_code_q <= shadow;
                vld_q       <= 1'b1;
                err_q       <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.skew_code_o = skew_code_q;
    assign bus.skew_load_o = load_q;
    assign bus.skew_vld_o  = vld_q;
    assign bus.seq_err_o   = err_q;
    assign bus.busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mc_rb_skew_fuse_cap.sv
// ---------------------------------------------------------------------------
// tb_mc_rb_skew_fuse_cap
// Self-checking bench for mc_rb_skew_fuse_cap. Complete sequences push their
// expected code to a scoreboard queue; a monitor pops and compares on every
// load strobe. Error/busy behaviour for short address patterns comes from a
// vector table; resets, aborts and back-to-back sequences are hand-written.
// ---------------------------------------------------------------------------
module tb_mc_rb_skew_fuse_cap;

    localparam int NL     = 4;
    localparam int SW     = 5;
    localparam int AW     = 5;
    localparam int CW     = NL * SW;
    localparam int LAST   = 20;
    localparam int NVEC   = 15;

    typedef struct {
        logic [AW-1:0] addr;
        logic          data;
        logic          exp_err;
        logic          exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    logic [CW-1:0] exp_q[$];
    logic          load_prev = 1'b0;

    vec_t tbl [NVEC];

    always #5 clk = ~clk;

    mc_rb_skew_fuse_cap_if #(.NUM_LANES(NL), .SKEW_W(SW), .ADDR_W(AW)) bus ();

    mc_rb_skew_fuse_cap #(
        .NUM_LANES (NL),
        .SKEW_W    (SW),
        .ADDR_W    (AW)
    ) dut (
        .mc_rb_ef1_sclk_i   (clk),
        .gctl_rclk_orst_n_i (rst_n),
        .bus                (bus)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one address/data pair and let the DUT sample it on the next edge.
    task automatic apply_stimulus(input logic [AW-1:0] a, input logic d);
        bus.skew_addr_cntr_i  = a;
        bus.mc_rb_ef1_sdata_i = d;
        step();
    endtask

    // Address k carries bits[k-1].
    task automatic drive_range(input logic [CW-1:0] bits, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            apply_stimulus(AW'(k), bits[k-1]);
        end
    endtask

    task automatic run_seq(input logic [CW-1:0] bits);
        exp_q.push_back(bits);
        drive_range(bits, 1, LAST);
    endtask

    // Scoreboard monitor: every load pulse must match a pending complete
    // sequence and must not follow another load pulse directly.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.skew_load_o === 1'b1) begin
            check_output("load_not_consecutive", {31'd0, load_prev}, 32'd0);
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL unexpected_load: got code 0x%0h, expected no load", bus.skew_code_o);
            end else begin
                logic [CW-1:0] want;
                want = exp_q.pop_front();
                if (bus.skew_code_o === want) begin
                    n_pass++;
                end else begin
                    $display("[TB] FAIL sb_code: got 0x%0h, expected 0x%0h", bus.skew_code_o, want);
                end
            end
        end
        load_prev = (rst_n === 1'b1) ? bus.skew_load_o : 1'b0;
    end

    initial begin
        logic [CW-1:0] pat_a;
        logic [CW-1:0] pat_b;
        logic [CW-1:0] pat_c;
        logic [CW-1:0] pat_d;
        logic [CW-1:0] pat_e;
        logic [CW-1:0] ones;

        // lane3..lane0 = 01010 11111 10000 01101
        pat_a = 20'b01010_11111_10000_01101;
        pat_b = 20'hA5C3E;
        pat_c = 20'h3C96B;
        pat_d = 20'h12345;
        pat_e = 20'hEDCBA;
        ones  = 20'hFFFFF;

        // Out-of-order 1,2,3,5 then idle noise and a stray mid-sequence address.
        tbl[0]  = '{addr: 5'd1,  data: 1'b1, exp_err: 1'b0, exp_busy: 1'b1};
        tbl[1]  = '{addr: 5'd2,  data: 1'b0, exp_err: 1'b0, exp_busy: 1'b1};
        tbl[2]  = '{addr: 5'd3,  data: 1'b1, exp_err: 1'b0, exp_busy: 1'b1};
        tbl[3]  = '{addr: 5'd5,  data: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
        tbl[4]  = '{addr: 5'd21, data: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
        tbl[5]  = '{addr: 5'd22, data: 1'b0, exp_err: 1'b0, exp_busy: 1'b0};
        tbl[6]  = '{addr: 5'd25, data: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
        tbl[7]  = '{addr: 5'd31, data: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
        tbl[8]  = '{addr: 5'd0,  data: 1'b0, exp_err: 1'b0, exp_busy: 1'b0};
        tbl[9]  = '{addr: 5'd24, data: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
        tbl[10] = '{addr: 5'd27, data: 1'b0, exp_err: 1'b0, exp_busy: 1'b0};
        tbl[11] = '{addr: 5'd30, data: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
        tbl[12] = '{addr: 5'd0,  data: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
        tbl[13] = '{addr: 5'd23, data: 1'b0, exp_err: 1'b0, exp_busy: 1'b0};
        tbl[14] = '{addr: 5'd9,  data: 1'b1, exp_err: 1'b1, exp_busy: 1'b0};

        // Reset state
        rst_n = 1'b0;
        bus.skew_addr_cntr_i  = '0;
        bus.mc_rb_ef1_sdata_i = 1'b0;
        step();
        step();
        check_output("rst_code", 32'(bus.skew_code_o), 32'd0);
        check_output("rst_load", 32'(bus.skew_load_o), 32'd0);
        check_output("rst_vld",  32'(bus.skew_vld_o),  32'd0);
        check_output("rst_err",  32'(bus.seq_err_o),   32'd0);
        check_output("rst_busy", 32'(bus.busy_o),      32'd0);
        rst_n = 1'b1;
        apply_stimulus(5'd0, 1'b0);

        // Clean sequence A with latency check
        run_seq(pat_a);
        check_output("a_commit_busy", 32'(bus.busy_o), 32'd1);
        check_output("a_early_load",  32'(bus.skew_load_o), 32'd0);
        apply_stimulus(5'd0, 1'b0);
        check_output("a_load",  32'(bus.skew_load_o), 32'd1);
        check_output("a_lane0", 32'(bus.skew_code_o[4:0]),   32'(5'b01101));
        check_output("a_lane1", 32'(bus.skew_code_o[9:5]),   32'(5'b10000));
        check_output("a_lane2", 32'(bus.skew_code_o[14:10]), 32'(5'b11111));
        check_output("a_lane3", 32'(bus.skew_code_o[19:15]), 32'(5'b01010));
        check_output("a_vld",   32'(bus.skew_vld_o), 32'd1);
        check_output("a_err",   32'(bus.seq_err_o),  32'd0);
        check_output("a_busy",  32'(bus.busy_o),     32'd0);
        apply_stimulus(5'd0, 1'b0);
        check_output("a_load_drop", 32'(bus.skew_load_o), 32'd0);

        // Abort after address 7
        drive_range(pat_b, 1, 7);
        check_output("abort_busy_mid", 32'(bus.busy_o), 32'd1);
        apply_stimulus(5'd0, 1'b0);
        check_output("abort_err",  32'(bus.seq_err_o), 32'd1);
        check_output("abort_busy", 32'(bus.busy_o),    32'd0);
        repeat (3) apply_stimulus(5'd0, 1'b0);
        check_output("abort_code_hold", 32'(bus.skew_code_o), 32'(pat_a));
        check_output("abort_load",      32'(bus.skew_load_o), 32'd0);
        check_output("abort_vld",       32'(bus.skew_vld_o),  32'd1);

        // Clean sequence B clears the error
        run_seq(pat_b);
        apply_stimulus(5'd0, 1'b0);
        check_output("b_load", 32'(bus.skew_load_o), 32'd1);
        check_output("b_err",  32'(bus.seq_err_o),   32'd0);
        check_output("b_code", 32'(bus.skew_code_o), 32'(pat_b));

        // Out-of-order vectors
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(tbl[i].addr, tbl[i].data);
            check_output($sformatf("vec%0d_err", i),  32'(bus.seq_err_o), 32'(tbl[i].exp_err));
            check_output($sformatf("vec%0d_busy", i), 32'(bus.busy_o),    32'(tbl[i].exp_busy));
        end

        // Clean sequence C after the out-of-order error
        run_seq(pat_c);
        apply_stimulus(5'd0, 1'b0);
        check_output("c_load", 32'(bus.skew_load_o), 32'd1);
        check_output("c_err",  32'(bus.seq_err_o),   32'd0);

        // Idle noise, then a stray address 9
        for (int i = 4; i < NVEC; i++) begin
            apply_stimulus(tbl[i].addr, tbl[i].data);
            check_output($sformatf("vec%0d_err", i),  32'(bus.seq_err_o), 32'(tbl[i].exp_err));
            check_output($sformatf("vec%0d_busy", i), 32'(bus.busy_o),    32'(tbl[i].exp_busy));
        end
        check_output("noise_code_hold", 32'(bus.skew_code_o), 32'(pat_c));
        apply_stimulus(5'd0, 1'b0);

        // Reset in the middle of a capture
        drive_range(ones, 1, 12);
        bus.skew_addr_cntr_i = 5'd13;
        rst_n = 1'b0;
        step();
        check_output("midrst_code", 32'(bus.skew_code_o), 32'd0);
        check_output("midrst_vld",  32'(bus.skew_vld_o),  32'd0);
        check_output("midrst_err",  32'(bus.seq_err_o),   32'd0);
        check_output("midrst_busy", 32'(bus.busy_o),      32'd0);
        check_output("midrst_load", 32'(bus.skew_load_o), 32'd0);
        rst_n = 1'b1;
        apply_stimulus(5'd0, 1'b0);
        run_seq(ones);
        apply_stimulus(5'd0, 1'b0);
        check_output("ones_code", 32'(bus.skew_code_o), 32'h000FFFFF);
        check_output("ones_vld",  32'(bus.skew_vld_o),  32'd1);

        // Back-to-back sequences with the minimum gap
        apply_stimulus(5'd0, 1'b0);
        run_seq(pat_d);
        apply_stimulus(5'd0, 1'b0);
        check_output("d_load", 32'(bus.skew_load_o), 32'd1);
        run_seq(pat_e);
        apply_stimulus(5'd0, 1'b0);
        check_output("e_load", 32'(bus.skew_load_o), 32'd1);
        check_output("e_code", 32'(bus.skew_code_o), 32'(pat_e));
        check_output("e_err",  32'(bus.seq_err_o),   32'd0);

        // Every pushed expectation must have been consumed by a load pulse
        repeat (4) apply_stimulus(5'd0, 1'b0);
        check_output("sb_pending", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
